// File: rtl/debounce_pkg.sv
// Shared defaults and width helpers for the debounce bank.
// Edge-pulse outputs are built only when DEBOUNCE_EDGE_EN is defined.
package debounce_pkg;

  localparam int DEF_N_BTN        = 4;
  localparam int DEF_N_SW         = 8;
  localparam int DEF_SAMPLE_DIV   = 100000;
  localparam int DEF_STABLE_TICKS = 4;

  // Mismatch counter must hold 0..STABLE_TICKS-1; one extra code keeps STABLE_TICKS=1 legal.
  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks < 2) ? 1 : $clog2(stable_ticks + 1);
  endfunction

  function automatic int div_width(input int sample_div);
    return (sample_div < 2) ? 1 : $clog2(sample_div);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stable level with mismatch counter,
// and (with DEBOUNCE_EDGE_EN defined) registered rise/fall pulses.
module debounce_chan
  import debounce_pkg::*;
#(
`ifdef DEBOUNCE_EDGE_EN
  parameter bit EDGE_EN      = 1'b1,
`endif
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw_in,
`ifdef DEBOUNCE_EDGE_EN
  output logic rise_pulse,
  output logic fall_pulse,
`endif
  output logic level
);

  localparam int              CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
        // Saturating compare: the counter can never step past the last code.
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

`ifdef DEBOUNCE_EDGE_EN
  generate
    if (EDGE_EN) begin : g_edge
      logic rise_q, rise_d;
      logic fall_q, fall_d;

      // Pulses come from level_d so they line up with the cycle level_q changes.
      always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= rise_d;
          fall_q <= fall_d;
        end
      end

      assign rise_pulse = rise_q;
      assign fall_pulse = fall_q;
    end else begin : g_no_edge
      assign rise_pulse = 1'b0;
      assign fall_pulse = 1'b0;
    end
  endgenerate
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of debounced buttons and switches sharing one sample prescaler.
// Define DEBOUNCE_EDGE_EN to add btn_press/btn_release pulse outputs.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int N_SW         = DEF_N_SW,
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_ok,
  output logic [N_SW-1:0]  sw_ok,
`ifdef DEBOUNCE_EDGE_EN
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
`endif
  output logic             sample_tick
);

  localparam int            DW       = div_width(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  // tick_q is a flop that is high exactly while div_q sits at DIV_LAST.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    tick_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_chan #(
`ifdef DEBOUNCE_EDGE_EN
      .EDGE_EN      (1'b1),
`endif
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick_q),
      .raw_in     (btn_in[i]),
`ifdef DEBOUNCE_EDGE_EN
      .rise_pulse (btn_press[i]),
      .fall_pulse (btn_release[i]),
`endif
      .level      (btn_ok[i])
    );
  end

`ifdef DEBOUNCE_EDGE_EN
  // Switch channels carry no edge registers; their tied-off pulse pins land here.
  logic [N_SW-1:0] sw_rise_unused;
  logic [N_SW-1:0] sw_fall_unused;
`endif

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_chan #(
`ifdef DEBOUNCE_EDGE_EN
      .EDGE_EN      (1'b0),
`endif
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick_q),
      .raw_in     (sw_in[j]),
`ifdef DEBOUNCE_EDGE_EN
      .rise_pulse (sw_rise_unused[j]),
      .fall_pulse (sw_fall_unused[j]),
`endif
      .level      (sw_ok[j])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: SAMPLE_DIV=4, STABLE_TICKS=3, 2 buttons, 2 switches.
// Edge-pulse checks apply when DEBOUNCE_EDGE_EN is defined, otherwise they expect 0.
module tb_debounce_bank;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] sw_in  = 2'b00;
  logic [1:0] btn_ok;
  logic [1:0] sw_ok;
  logic       sample_tick;
`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] btn_press;
  logic [1:0] btn_release;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_BTN        (2),
    .N_SW         (2),
    .SAMPLE_DIV   (4),
    .STABLE_TICKS (3)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .sw_in       (sw_in),
    .btn_ok      (btn_ok),
    .sw_ok       (sw_ok),
`ifdef DEBOUNCE_EDGE_EN
    .btn_press   (btn_press),
    .btn_release (btn_release),
`endif
    .sample_tick (sample_tick)
  );

  // Observation vector: {sample_tick, btn_ok[1:0], sw_ok[1:0], press[1:0], release[1:0]}
  function automatic logic [8:0] obs_vec();
    logic [1:0] pr;
    logic [1:0] rl;
    pr = 2'b00;
    rl = 2'b00;
`ifdef DEBOUNCE_EDGE_EN
    pr = btn_press;
    rl = btn_release;
`endif
    return {sample_tick, btn_ok, sw_ok, pr, rl};
  endfunction

  function automatic logic [8:0] exp_vec(input logic tk, input logic [1:0] bok,
                                         input logic [1:0] sok, input logic [1:0] pr_in,
                                         input logic [1:0] rl_in);
    logic [1:0] pr;
    logic [1:0] rl;
    pr = pr_in;
    rl = rl_in;
`ifndef DEBOUNCE_EDGE_EN
    pr = 2'b00;
    rl = 2'b00;
`endif
    return {tk, bok, sok, pr, rl};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %b expected %b (tick,btn_ok,sw_ok,press,release)",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic align_tick(input string tag);
    for (int i = 0; i < 8 && !sample_tick; i++) step();
    chk(tag, {8'b0, sample_tick}, 9'd1);
  endtask

  // Checks n_cyc negedges; state changes to (bok1,sok1) at negedge t_upd with pulses there.
  task automatic window(input string tag, input int n_cyc, input int t_upd, input int ph,
                        input logic [1:0] bok0, input logic [1:0] sok0,
                        input logic [1:0] bok1, input logic [1:0] sok1,
                        input logic [1:0] pr, input logic [1:0] rl);
    logic [8:0] e;
    for (int n = 1; n <= n_cyc; n++) begin
      step();
      if (n < t_upd)
        e = exp_vec((n % 4) == ph, bok0, sok0, 2'b00, 2'b00);
      else
        e = exp_vec((n % 4) == ph, bok1, sok1,
                    (n == t_upd) ? pr : 2'b00, (n == t_upd) ? rl : 2'b00);
      chk($sformatf("%s n=%0d", tag, n), obs_vec(), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("in_reset", obs_vec(), 9'd0);

    // Idle after reset: tick on cycles 3, 7, 11; everything else stays 0.
    rst_n = 1'b1;
    chk("idle n=0", obs_vec(), exp_vec(1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    window("idle", 12, 1000, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Clean press on btn 0: visible 13 negedges after the change on a tick cycle.
    align_tick("align_press0");
    btn_in[0] = 1'b1;
    window("press0", 14, 13, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);

    // btn 1 toggles every cycle; phase chosen so each tick samples 0.
    align_tick("align_toggle");
    for (int n = 0; n < 40; n++) begin
      btn_in[1] = ((n % 2) == 1);
      step();
      chk($sformatf("toggle n=%0d", n + 1), obs_vec(),
          exp_vec(((n + 1) % 4) == 0, 2'b01, 2'b00, 2'b00, 2'b00));
    end
    btn_in[1] = 1'b0;
    window("toggle_tail", 8, 1000, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

    // Switches: high 2 ticks, low 1 tick, high again; qualification restarts.
    align_tick("align_sw");
    sw_in = 2'b11;
    for (int n = 1; n <= 26; n++) begin
      step();
      chk($sformatf("sw_restart n=%0d", n), obs_vec(),
          exp_vec((n % 4) == 0, 2'b01, (n >= 25) ? 2'b11 : 2'b00, 2'b00, 2'b00));
      if (n == 8)  sw_in = 2'b00;
      if (n == 12) sw_in = 2'b11;
    end

    // Reset with btn 1 two ticks into qualification.
    align_tick("align_rst");
    btn_in[1] = 1'b1;
    window("pre_rst", 9, 1000, 0, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async", obs_vec(), 9'd0);
    step();
    rst_n = 1'b1;
    chk("rst_release", obs_vec(), 9'd0);
    window("requal", 13, 12, 3, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);

    // Release btn 1 alone, then swap both buttons in one cycle.
    align_tick("align_rel1");
    btn_in[1] = 1'b0;
    window("release1", 14, 13, 0, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10);

    align_tick("align_swap");
    btn_in = 2'b10;
    window("swap", 14, 13, 0, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
